// File: rtl/mux21_rr_arbiter_if.sv
// Two streaming sources plus one registered output stream.
// The arbiter uses the master view; the sources and sink use the slave view.
interface mux21_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;

  modport master (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Round-robin owner of a 2:1 select path between sources A and B.
// A grant lasts for a whole packet, ended by last or by a beat-count cap;
// the selected beat lands in a single registered output stage.
//
// state | meaning
// IDLE  | no owner; pick next owner from requests and prio
// OWN_A | A owns the mux (sel = 0) until its packet ends or hits the cap
// OWN_B | B owns the mux (sel = 1) until its packet ends or hits the cap
module mux21_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux21_rr_arbiter_if.master     bus,
  output logic                   sel,
  output logic                   overrun
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t             state, state_nxt;
  logic               prio;
  logic [CNT_W-1:0]   beat_cnt;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_src;

  logic               space;
  logic               owner_valid;
  logic               owner_last;
  logic [WIDTH-1:0]   owner_data;
  logic               xfer;
  logic               cap;
  logic               release_grant;

  // The output stage can take a beat when empty or being drained this cycle.
  assign space         = ~out_valid | bus.out_ready;
  assign owner_valid   = sel ? bus.b_valid : bus.a_valid;
  assign owner_last    = sel ? bus.b_last  : bus.a_last;
  assign owner_data    = sel ? bus.b_data  : bus.a_data;
  assign xfer          = (state != IDLE) & owner_valid & space;
  assign cap           = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign release_grant = xfer & (owner_last | cap);

  assign bus.a_ready   = (state == OWN_A) & space;
  assign bus.b_ready   = (state == OWN_B) & space;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_src   = out_src;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: grant from IDLE with prio as tie-break, release on last or cap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || !prio)) state_nxt = OWN_A;
        else if (bus.b_valid)                        state_nxt = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (release_grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select, priority, beat counter, overrun pulse and the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 1'b0;
      prio      <= 1'b0;
      beat_cnt  <= '0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      overrun <= xfer & cap & ~owner_last;
      if (state == IDLE) begin
        if (state_nxt == OWN_A)      sel <= 1'b0;
        else if (state_nxt == OWN_B) sel <= 1'b1;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= owner_data;
        out_last  <= owner_last | cap;
        out_src   <= sel;
        if (release_grant) begin
          beat_cnt <= '0;
          prio     <= ~sel;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Directed bench for mux21_rr_arbiter, built with MAX_BEATS = 4 so the cap
// case is reachable; all other packets stay below four beats.
module tb_mux21_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic overrun;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux21_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux21_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .sel     (sel),
    .overrun (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic s);
    chk({tag, ".valid"}, 16'(bus.out_valid), 16'(v));
    if (v) begin
      chk({tag, ".data"}, 16'(bus.out_data), 16'(d));
      chk({tag, ".last"}, 16'(bus.out_last), 16'(l));
      chk({tag, ".src"},  16'(bus.out_src),  16'(s));
    end
  endtask

  task automatic chk_rdy(input string tag, input logic ar, input logic br);
    chk({tag, ".a_ready"}, 16'(bus.a_ready), 16'(ar));
    chk({tag, ".b_ready"}, 16'(bus.b_ready), 16'(br));
  endtask

  task automatic drv_a(input logic v, input logic [7:0] d, input logic l);
    bus.a_valid = v; bus.a_data = d; bus.a_last = l;
  endtask

  task automatic drv_b(input logic v, input logic [7:0] d, input logic l);
    bus.b_valid = v; bus.b_data = d; bus.b_last = l;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_a(0, 8'h00, 0);
    drv_b(0, 8'h00, 0);
    bus.out_ready = 1'b1;
    tick(); tick();
    // reset values
    chk("rst.sel", 16'(sel), 16'd0);
    chk("rst.overrun", 16'(overrun), 16'd0);
    chk("rst.out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst.out_data", 16'(bus.out_data), 16'd0);
    chk("rst.out_last", 16'(bus.out_last), 16'd0);
    chk("rst.out_src", 16'(bus.out_src), 16'd0);
    chk_rdy("rst", 0, 0);
    rst_n = 1'b1;
    tick();

    // ---- single A packet 0x11,0x22,0x33 ----
    drv_a(1, 8'h11, 0);
    #1 chk_rdy("a1.idle", 0, 0);
    tick();                                   // owner A
    chk("a1.sel", 16'(sel), 16'd0);
    chk_rdy("a1.own", 1, 0);
    chk_out("a1.e1", 0, 8'h00, 0, 0);
    tick();                                   // 2 cycles after a_valid
    chk_out("a1.b1", 1, 8'h11, 0, 0);
    drv_a(1, 8'h22, 0);
    tick();
    chk_out("a1.b2", 1, 8'h22, 0, 0);
    drv_a(1, 8'h33, 1);
    tick();
    chk_out("a1.b3", 1, 8'h33, 1, 0);
    chk_rdy("a1.rel", 0, 0);
    drv_a(0, 8'h00, 0);
    tick();
    chk_out("a1.drain", 0, 8'h00, 0, 0);

    // ---- contention: prio is now 1, so B wins first, then A, B, A ----
    drv_a(1, 8'hA1, 0);
    drv_b(1, 8'hB1, 0);
    tick();
    chk("c.g1.sel", 16'(sel), 16'd1);
    chk_rdy("c.g1", 0, 1);
    tick();
    chk_out("c.b1", 1, 8'hB1, 0, 1);
    drv_b(1, 8'hB2, 1);
    tick();
    chk_out("c.b2", 1, 8'hB2, 1, 1);
    chk_rdy("c.bub1", 0, 0);
    drv_b(1, 8'hB3, 0);
    tick();
    chk("c.g2.sel", 16'(sel), 16'd0);
    chk_rdy("c.g2", 1, 0);
    chk_out("c.g2", 0, 8'h00, 0, 0);
    tick();
    chk_out("c.a1", 1, 8'hA1, 0, 0);
    drv_a(1, 8'hA2, 1);
    tick();
    chk_out("c.a2", 1, 8'hA2, 1, 0);
    drv_a(1, 8'hA3, 0);
    tick();
    chk("c.g3.sel", 16'(sel), 16'd1);
    chk_out("c.g3", 0, 8'h00, 0, 0);
    tick();
    chk_out("c.b3", 1, 8'hB3, 0, 1);
    drv_b(1, 8'hB4, 1);
    tick();
    chk_out("c.b4", 1, 8'hB4, 1, 1);
    drv_b(0, 8'h00, 0);
    tick();
    chk("c.g4.sel", 16'(sel), 16'd0);
    chk_out("c.g4", 0, 8'h00, 0, 0);
    tick();
    chk_out("c.a3", 1, 8'hA3, 0, 0);
    drv_a(1, 8'hA4, 1);
    tick();
    chk_out("c.a4", 1, 8'hA4, 1, 0);

    // ---- backpressure: out_ready low for 4 cycles mid-packet ----
    drv_a(1, 8'h51, 0);
    tick();
    chk("bp.sel", 16'(sel), 16'd0);
    chk_out("bp.g", 0, 8'h00, 0, 0);
    tick();
    chk_out("bp.b1", 1, 8'h51, 0, 0);
    drv_a(1, 8'h52, 0);
    bus.out_ready = 1'b0;
    #1 chk_rdy("bp.stall0", 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp.hold", 1, 8'h51, 0, 0);
      chk_rdy("bp.stall", 0, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp.b2", 1, 8'h52, 0, 0);
    drv_a(1, 8'h53, 1);
    tick();
    chk_out("bp.b3", 1, 8'h53, 1, 0);
    drv_a(0, 8'h00, 0);
    tick();
    chk_out("bp.drain", 0, 8'h00, 0, 0);

    // ---- cap at 4 beats: A streams without last while B waits ----
    drv_a(1, 8'hC1, 0);
    tick();
    chk("cap.sel", 16'(sel), 16'd0);
    drv_b(1, 8'hD1, 1);
    tick();
    chk_out("cap.c1", 1, 8'hC1, 0, 0);
    drv_a(1, 8'hC2, 0);
    tick();
    chk_out("cap.c2", 1, 8'hC2, 0, 0);
    drv_a(1, 8'hC3, 0);
    tick();
    chk_out("cap.c3", 1, 8'hC3, 0, 0);
    chk("cap.ovr0", 16'(overrun), 16'd0);
    drv_a(1, 8'hC4, 0);
    tick();
    chk_out("cap.c4", 1, 8'hC4, 1, 0);
    chk("cap.ovr", 16'(overrun), 16'd1);
    chk_rdy("cap.rel", 0, 0);
    drv_a(1, 8'hC5, 0);
    tick();
    chk("cap.ovr_end", 16'(overrun), 16'd0);
    chk("cap.gb.sel", 16'(sel), 16'd1);
    chk_rdy("cap.gb", 0, 1);
    tick();
    chk_out("cap.d1", 1, 8'hD1, 1, 1);
    drv_b(0, 8'h00, 0);
    tick();
    chk("cap.ga.sel", 16'(sel), 16'd0);
    tick();
    chk_out("cap.c5", 1, 8'hC5, 0, 0);
    drv_a(1, 8'hC6, 0);
    tick();
    chk_out("cap.c6", 1, 8'hC6, 0, 0);
    drv_a(0, 8'h00, 0);
    tick();
    // A idles mid-packet: grant held, B ignored
    chk_out("hold.idle", 0, 8'h00, 0, 0);
    chk("hold.sel", 16'(sel), 16'd0);
    drv_a(1, 8'hC7, 1);
    drv_b(1, 8'hE1, 0);
    #1 chk_rdy("hold.rdy", 1, 0);
    tick();
    chk_out("hold.c7", 1, 8'hC7, 1, 0);
    drv_a(0, 8'h00, 0);

    // ---- async reset during beat 2 of a B packet ----
    tick();
    chk("rb.sel", 16'(sel), 16'd1);
    tick();
    chk_out("rb.e1", 1, 8'hE1, 0, 1);
    drv_b(1, 8'hE2, 0);
    tick();
    chk_out("rb.e2", 1, 8'hE2, 0, 1);
    drv_a(1, 8'h61, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb.rst.sel", 16'(sel), 16'd0);
    chk("rb.rst.valid", 16'(bus.out_valid), 16'd0);
    chk("rb.rst.data", 16'(bus.out_data), 16'd0);
    chk_rdy("rb.rst", 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rb.after.sel", 16'(sel), 16'd0);
    chk_rdy("rb.after", 1, 0);
    tick();
    chk_out("rb.a", 1, 8'h61, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
